// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared types, digit indices, digit limits and the BCD
//               HH:MM:SS decrement helper for the clock/timer datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Digit positions inside the packed 24-bit value (4 bits per digit)
  localparam logic [2:0] SEC1  = 3'd0;
  localparam logic [2:0] SEC10 = 3'd1;
  localparam logic [2:0] MIN1  = 3'd2;
  localparam logic [2:0] MIN10 = 3'd3;
  localparam logic [2:0] HR1   = 3'd4;
  localparam logic [2:0] HR10  = 3'd5;

  localparam logic [3:0] DIG_LIM_UNITS = 4'd9;
  localparam logic [3:0] DIG_LIM_TENS  = 4'd5;

  typedef struct packed {
    logic [23:0] val;
    logic        zero;
  } dec_t;

  // Highest legal value of a digit position
  function automatic logic [3:0] digit_limit(input logic [2:0] idx,
                                             input logic [3:0] hr10_max);
    case (idx)
      SEC10, MIN10: return DIG_LIM_TENS;
      HR10:         return hr10_max;
      default:      return DIG_LIM_UNITS;
    endcase
  endfunction

  // One-second decrement with a BCD borrow chain from sec_1 up to hr_10.
  // hr_10 never needs to borrow because the timer only counts a non-zero value.
  function automatic dec_t bcd_dec_hms(input logic [23:0] v);
    dec_t r;
    logic borrow;
    r.val  = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r.val[i*4 +: 4] = digit_limit(3'(i), 4'd0);
        end else begin
          r.val[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
    r.zero = (r.val == 24'd0);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge
// Description : Two-flop synchroniser followed by a rising-edge detector with
//               a registered one-cycle pulse output.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  // Synchronise the raw button and emit one pulse per rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Editable HH:MM:SS countdown timer with pause/resume, preset
//               load and a timed alarm that restores the started value.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
  import clock_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int ALARM_SEC = 10,
  parameter int HR10_MAX  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       start,
  input  logic       load,
  input  logic       clear,
  input  logic [3:0] hr_10,
  input  logic [3:0] hr_1,
  input  logic [3:0] min_10,
  input  logic [3:0] min_1,
  input  logic [3:0] sec_10,
  input  logic [3:0] sec_1,
  output logic [3:0] hr_2_10,
  output logic [3:0] hr_2_1,
  output logic [3:0] min_2_10,
  output logic [3:0] min_2_1,
  output logic [3:0] sec_2_10,
  output logic [3:0] sec_2_1,
  output logic [2:0] cursor,
  output logic       running,
  output logic       paused,
  output logic       alarm
);

  localparam int            PW             = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] C_PRESC_LAST   = PW'(CLK_HZ - 1);
  localparam logic [7:0]    C_ALARM_LAST   = 8'(ALARM_SEC - 1);
  localparam logic [3:0]    C_HR10_LIM     = 4'(HR10_MAX);

  // Button index order: up, down, left, right, start, load, clear
  logic [6:0] w_btn_raw;
  logic [6:0] w_pulse;

  assign w_btn_raw = {clear, load, start, right, left, down, up};

  generate
    for (genvar g = 0; g < 7; g++) begin : g_btn
      btn_edge u_btn_edge (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (w_btn_raw[g]),
        .pulse_o (w_pulse[g])
      );
    end
  endgenerate

  logic w_up_only, w_dn_only, w_left_only, w_right_only;
  assign w_up_only    = w_pulse[0] & ~w_pulse[1];
  assign w_dn_only    = w_pulse[1] & ~w_pulse[0];
  assign w_left_only  = w_pulse[2] & ~w_pulse[3];
  assign w_right_only = w_pulse[3] & ~w_pulse[2];

  state_t        state_q, state_d;
  logic [23:0]   digits_q, digits_d;
  logic [23:0]   saved_q, saved_d;
  logic [2:0]    cursor_q, cursor_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    alarm_cnt_q, alarm_cnt_d;
  logic          running_q, paused_q, alarm_q;

  logic [23:0] w_preset;
  logic [23:0] w_load_val;
  logic [4:0]  w_sel_lsb;
  logic [3:0]  w_sel_val;
  logic [3:0]  w_sel_lim;
  logic        w_counting;
  logic        w_tick;
  dec_t        w_dec;

  assign w_preset   = {hr_10, hr_1, min_10, min_1, sec_10, sec_1};
  assign w_sel_lsb  = {cursor_q, 2'b00};
  assign w_sel_val  = digits_q[w_sel_lsb +: 4];
  assign w_sel_lim  = digit_limit(cursor_q, C_HR10_LIM);
  assign w_counting = (state_q == RUN) || (state_q == DONE);
  assign w_tick     = w_counting && (presc_q == C_PRESC_LAST);
  assign w_dec      = bcd_dec_hms(digits_q);

  // Saturate each preset digit to the limit of its position
  always_comb begin
    w_load_val = '0;
    for (int i = 0; i < 6; i++) begin
      if (w_preset[i*4 +: 4] > digit_limit(3'(i), C_HR10_LIM)) begin
        w_load_val[i*4 +: 4] = digit_limit(3'(i), C_HR10_LIM);
      end else begin
        w_load_val[i*4 +: 4] = w_preset[i*4 +: 4];
      end
    end
  end

  // Next-state, digit editing, countdown, prescaler and alarm counter
  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    saved_d     = saved_q;
    cursor_d    = cursor_q;
    alarm_cnt_d = alarm_cnt_q;

    if (w_pulse[6]) begin
      digits_d = '0;
      cursor_d = '0;
      state_d  = EDIT;
    end else begin
      case (state_q)
        EDIT: begin
          if (w_pulse[4]) begin
            if (digits_q != 24'd0) begin
              saved_d = digits_q;
              state_d = RUN;
            end
          end else if (w_pulse[5]) begin
            digits_d = w_load_val;
          end else if (w_up_only) begin
            digits_d[w_sel_lsb +: 4] = (w_sel_val >= w_sel_lim) ? 4'd0 : w_sel_val + 4'd1;
          end else if (w_dn_only) begin
            digits_d[w_sel_lsb +: 4] = (w_sel_val == 4'd0) ? w_sel_lim : w_sel_val - 4'd1;
          end else if (w_left_only) begin
            cursor_d = (cursor_q == HR10) ? SEC1 : cursor_q + 3'd1;
          end else if (w_right_only) begin
            cursor_d = (cursor_q == SEC1) ? HR10 : cursor_q - 3'd1;
          end
        end
        RUN: begin
          // A tick that expires the timer beats a simultaneous start
          if (w_tick && w_dec.zero) begin
            digits_d = w_dec.val;
            state_d  = DONE;
          end else if (w_pulse[4]) begin
            state_d = PAUSE;
          end else if (w_tick) begin
            digits_d = w_dec.val;
          end
        end
        PAUSE: begin
          if (w_pulse[4]) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if ((|w_pulse) || (w_tick && (alarm_cnt_q == C_ALARM_LAST))) begin
            digits_d = saved_q;
            state_d  = EDIT;
          end else if (w_tick) begin
            alarm_cnt_d = alarm_cnt_q + 8'd1;
          end
        end
        default: state_d = EDIT;
      endcase
    end

    // Every state entry restarts a full second and a fresh alarm count
    if ((state_d != state_q) || !w_counting || w_tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (state_d != state_q) begin
      alarm_cnt_d = '0;
    end
  end

  // State, datapath and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EDIT;
      digits_q    <= '0;
      saved_q     <= '0;
      cursor_q    <= '0;
      presc_q     <= '0;
      alarm_cnt_q <= '0;
      running_q   <= 1'b0;
      paused_q    <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      saved_q     <= saved_d;
      cursor_q    <= cursor_d;
      presc_q     <= presc_d;
      alarm_cnt_q <= alarm_cnt_d;
      running_q   <= (state_d == RUN);
      paused_q    <= (state_d == PAUSE);
      alarm_q     <= (state_d == DONE);
    end
  end

  assign sec_2_1  = digits_q[3:0];
  assign sec_2_10 = digits_q[7:4];
  assign min_2_1  = digits_q[11:8];
  assign min_2_10 = digits_q[15:12];
  assign hr_2_1   = digits_q[19:16];
  assign hr_2_10  = digits_q[23:20];
  assign cursor   = cursor_q;
  assign running  = running_q;
  assign paused   = paused_q;
  assign alarm    = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Directed self-checking bench for countdown_timer
//               (CLK_HZ=4, ALARM_SEC=2, HR10_MAX=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_START = 4;
  localparam int B_LOAD  = 5;
  localparam int B_CLEAR = 6;

  logic       clk;
  logic       reset;
  logic [6:0] btn;
  logic [3:0] p_hr10, p_hr1, p_min10, p_min1, p_sec10, p_sec1;
  logic [3:0] o_hr10, o_hr1, o_min10, o_min1, o_sec10, o_sec1;
  logic [2:0] cursor;
  logic       running, paused, alarm;
  logic [23:0] disp;

  int n_cmp;
  int n_bad;

  assign disp = {o_hr10, o_hr1, o_min10, o_min1, o_sec10, o_sec1};

  countdown_timer #(
    .CLK_HZ    (4),
    .ALARM_SEC (2),
    .HR10_MAX  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .up       (btn[B_UP]),
    .down     (btn[B_DOWN]),
    .left     (btn[B_LEFT]),
    .right    (btn[B_RIGHT]),
    .start    (btn[B_START]),
    .load     (btn[B_LOAD]),
    .clear    (btn[B_CLEAR]),
    .hr_10    (p_hr10),
    .hr_1     (p_hr1),
    .min_10   (p_min10),
    .min_1    (p_min1),
    .sec_10   (p_sec10),
    .sec_1    (p_sec1),
    .hr_2_10  (o_hr10),
    .hr_2_1   (o_hr1),
    .min_2_10 (o_min10),
    .min_2_1  (o_min1),
    .sec_2_10 (o_sec10),
    .sec_2_1  (o_sec1),
    .cursor   (cursor),
    .running  (running),
    .paused   (paused),
    .alarm    (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge: button seen by exactly one posedge N, returns at
  // the negedge after N+3 when the effect is visible.
  task automatic press(input int idx);
    btn[idx] = 1'b1;
    @(negedge clk);
    btn[idx] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (disp !== 24'h000000) begin n_bad++; $display("FAIL reset_digits: got %h want %h", disp, 24'h000000); end
    n_cmp++; if ({cursor, running, paused, alarm} !== 6'b0) begin n_bad++; $display("FAIL reset_status: got %b want %b", {cursor, running, paused, alarm}, 6'b0); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({disp, cursor, running, paused, alarm} !== 30'b0) begin n_bad++; $display("FAIL after_reset: got %h want %h", {disp, cursor, running, paused, alarm}, 30'b0); end
  endtask

  task automatic test_edit;
    repeat (3) press(B_UP);
    press(B_LEFT);
    repeat (7) press(B_UP);
    n_cmp++; if (disp !== 24'h000013) begin n_bad++; $display("FAIL edit_wrap: got %h want %h", disp, 24'h000013); end
    n_cmp++; if (cursor !== 3'd1) begin n_bad++; $display("FAIL edit_cursor_left: got %0d want %0d", cursor, 1); end
    press(B_RIGHT);
    repeat (4) press(B_DOWN);
    n_cmp++; if (disp !== 24'h000019) begin n_bad++; $display("FAIL edit_down_wrap: got %h want %h", disp, 24'h000019); end
    press(B_RIGHT);
    n_cmp++; if (cursor !== 3'd5) begin n_bad++; $display("FAIL edit_cursor_right_wrap: got %0d want %0d", cursor, 5); end
    press(B_DOWN);
    n_cmp++; if (disp !== 24'h200019) begin n_bad++; $display("FAIL edit_hr10_down: got %h want %h", disp, 24'h200019); end
    press(B_UP);
    n_cmp++; if (disp !== 24'h000019) begin n_bad++; $display("FAIL edit_hr10_up_wrap: got %h want %h", disp, 24'h000019); end
    press(B_CLEAR);
    n_cmp++; if ({disp, cursor} !== 27'b0) begin n_bad++; $display("FAIL edit_clear: got %h want %h", {disp, cursor}, 27'b0); end
    // A held button must act only once
    btn[B_UP] = 1'b1;
    repeat (6) @(negedge clk);
    btn[B_UP] = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (disp !== 24'h000001) begin n_bad++; $display("FAIL edit_hold_once: got %h want %h", disp, 24'h000001); end
    press(B_CLEAR);
  endtask

  task automatic test_borrow;
    p_hr1 = 4'd1;
    press(B_LOAD);
    p_hr1 = 4'd0;
    n_cmp++; if (disp !== 24'h010000) begin n_bad++; $display("FAIL borrow_load: got %h want %h", disp, 24'h010000); end
    press(B_START);
    repeat (3) @(negedge clk);
    n_cmp++; if (disp !== 24'h010000) begin n_bad++; $display("FAIL borrow_before_tick: got %h want %h", disp, 24'h010000); end
    @(negedge clk);
    n_cmp++; if (disp !== 24'h005959) begin n_bad++; $display("FAIL borrow_chain: got %h want %h", disp, 24'h005959); end
    repeat (4) @(negedge clk);
    n_cmp++; if (disp !== 24'h005958) begin n_bad++; $display("FAIL borrow_second: got %h want %h", disp, 24'h005958); end
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL borrow_running: got %b want %b", running, 1'b1); end
    press(B_CLEAR);
  endtask

  task automatic test_pause;
    repeat (5) press(B_UP);
    press(B_START);
    // This start lands on the first tick; value is not expiring, so start wins
    press(B_START);
    n_cmp++; if ({running, paused} !== 2'b01) begin n_bad++; $display("FAIL pause_state: got %b want %b", {running, paused}, 2'b01); end
    n_cmp++; if (disp !== 24'h000005) begin n_bad++; $display("FAIL pause_no_dec: got %h want %h", disp, 24'h000005); end
    repeat (40) @(negedge clk);
    n_cmp++; if (disp !== 24'h000005 || paused !== 1'b1) begin n_bad++; $display("FAIL pause_hold: got %h/%b want %h/%b", disp, paused, 24'h000005, 1'b1); end
    press(B_START);
    repeat (3) @(negedge clk);
    n_cmp++; if (disp !== 24'h000005 || running !== 1'b1) begin n_bad++; $display("FAIL resume_early: got %h/%b want %h/%b", disp, running, 24'h000005, 1'b1); end
    @(negedge clk);
    n_cmp++; if (disp !== 24'h000004) begin n_bad++; $display("FAIL resume_first_dec: got %h want %h", disp, 24'h000004); end
    press(B_CLEAR);
  endtask

  task automatic test_expiry;
    repeat (2) press(B_UP);
    press(B_LEFT);
    press(B_START);
    repeat (7) @(negedge clk);
    n_cmp++; if (disp !== 24'h000001 || alarm !== 1'b0) begin n_bad++; $display("FAIL expiry_pre: got %h/%b want %h/%b", disp, alarm, 24'h000001, 1'b0); end
    @(negedge clk);
    n_cmp++; if (disp !== 24'h000000 || {running, alarm} !== 2'b01) begin n_bad++; $display("FAIL expiry_done: got %h/%b want %h/%b", disp, {running, alarm}, 24'h000000, 2'b01); end
    repeat (7) @(negedge clk);
    n_cmp++; if (alarm !== 1'b1) begin n_bad++; $display("FAIL alarm_hold: got %b want %b", alarm, 1'b1); end
    @(negedge clk);
    n_cmp++; if (alarm !== 1'b0 || disp !== 24'h000002) begin n_bad++; $display("FAIL alarm_restore: got %b/%h want %b/%h", alarm, disp, 1'b0, 24'h000002); end
    n_cmp++; if (cursor !== 3'd1) begin n_bad++; $display("FAIL alarm_cursor_kept: got %0d want %0d", cursor, 1); end
    press(B_START);
    repeat (8) @(negedge clk);
    n_cmp++; if (alarm !== 1'b1) begin n_bad++; $display("FAIL expiry2_done: got %b want %b", alarm, 1'b1); end
    press(B_DOWN);
    n_cmp++; if ({running, paused, alarm} !== 3'b000 || disp !== 24'h000002) begin n_bad++; $display("FAIL done_button_exit: got %b/%h want %b/%h", {running, paused, alarm}, disp, 3'b000, 24'h000002); end
    press(B_CLEAR);
  endtask

  task automatic test_edge_cases;
    press(B_START);
    n_cmp++; if (running !== 1'b0 || disp !== 24'h000000) begin n_bad++; $display("FAIL start_at_zero: got %b/%h want %b/%h", running, disp, 1'b0, 24'h000000); end
    p_hr10 = 4'd7; p_hr1 = 4'd9; p_min10 = 4'd8; p_min1 = 4'd9; p_sec10 = 4'd6; p_sec1 = 4'd3;
    press(B_LOAD);
    p_hr10 = 4'd0; p_hr1 = 4'd0; p_min10 = 4'd0; p_min1 = 4'd0; p_sec10 = 4'd0; p_sec1 = 4'd0;
    n_cmp++; if (disp !== 24'h295953) begin n_bad++; $display("FAIL load_saturate: got %h want %h", disp, 24'h295953); end
    press(B_CLEAR);
    press(B_UP);
    press(B_START);
    press(B_START);
    n_cmp++; if ({running, paused, alarm} !== 3'b001 || disp !== 24'h000000) begin n_bad++; $display("FAIL final_tick_wins: got %b/%h want %b/%h", {running, paused, alarm}, disp, 3'b001, 24'h000000); end
    press(B_CLEAR);
    n_cmp++; if (alarm !== 1'b0 || disp !== 24'h000000) begin n_bad++; $display("FAIL clear_in_done: got %b/%h want %b/%h", alarm, disp, 1'b0, 24'h000000); end
    repeat (3) press(B_UP);
    press(B_LEFT);
    press(B_START);
    repeat (5) @(negedge clk);
    n_cmp++; if (disp !== 24'h000002 || running !== 1'b1) begin n_bad++; $display("FAIL pre_async_reset: got %h/%b want %h/%b", disp, running, 24'h000002, 1'b1); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if ({disp, cursor, running, paused, alarm} !== 30'b0) begin n_bad++; $display("FAIL async_reset: got %h want %h", {disp, cursor, running, paused, alarm}, 30'b0); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    btn     = '0;
    p_hr10  = '0; p_hr1  = '0; p_min10 = '0;
    p_min1  = '0; p_sec10 = '0; p_sec1 = '0;
    reset   = 1'b1;
    test_reset();
    test_edit();
    test_borrow();
    test_pause();
    test_expiry();
    test_edge_cases();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
